// File: rtl/rammodel_lat_queue.sv
// Timed response queue for the RAM model: FIFO of payloads, each released once model time reaches its deadline.
// Optional statistics outputs (stat_enq, stat_bp, stat_max_occ) are enabled by defining RAMMODEL_LAT_STAT_EN.
module rammodel_lat_queue #(
  parameter int DATA_WIDTH = 72,
  parameter int DEPTH      = 16,
  parameter int LAT_WIDTH  = 8,
  parameter int TS_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic [LAT_WIDTH-1:0]    latency,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic [TS_WIDTH-1:0]     now,
  output logic                    stall_gen
`ifdef RAMMODEL_LAT_STAT_EN
  ,
  output logic [31:0]             stat_enq,
  output logic [31:0]             stat_bp,
  output logic [$clog2(DEPTH):0]  stat_max_occ
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [TS_WIDTH-1:0]   r_dl   [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [TS_WIDTH-1:0]   r_now;

  logic                  w_nonempty;
  logic                  w_full;
  logic                  w_due;
  logic                  w_enq;
  logic                  w_deq;
  logic [TS_WIDTH-1:0]   w_age;
  logic [TS_WIDTH-1:0]   w_deadline;

  // Wrap-safe due test: latency stays below half the time range, so a
  // non-negative signed age means the deadline has been reached.
  assign w_age      = r_now - r_dl[r_rptr];
  assign w_due      = ~w_age[TS_WIDTH-1];
  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_deadline = r_now + TS_WIDTH'(latency);

  assign in_ready  = !rst && !stall && !w_full;
  assign out_valid = !stall && w_nonempty && w_due;
  assign stall_gen = w_nonempty && w_due && !out_ready;
  assign out_data  = r_data[r_rptr];
  assign count     = r_count;
  assign now       = r_now;

  assign w_enq = in_valid && in_ready;
  assign w_deq = out_valid && out_ready;

  // Entry storage needs no reset: slots are only read once counted valid.
  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_data[r_wptr] <= in_data;
      r_dl[r_wptr]   <= w_deadline;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_now   <= '0;
    end else if (!stall) begin
      r_now <= r_now + 1'b1;
      if (w_enq) r_wptr <= r_wptr + 1'b1;
      if (w_deq) r_rptr <= r_rptr + 1'b1;
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef RAMMODEL_LAT_STAT_EN
  logic [31:0]   r_stat_enq;
  logic [31:0]   r_stat_bp;
  logic [CW-1:0] r_stat_max;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_enq <= '0;
      r_stat_bp  <= '0;
      r_stat_max <= '0;
    end else if (!stall) begin
      if (w_enq && (r_stat_enq != '1)) r_stat_enq <= r_stat_enq + 1'b1;
      if (stall_gen && (r_stat_bp != '1)) r_stat_bp <= r_stat_bp + 1'b1;
      if (r_count > r_stat_max) r_stat_max <= r_count;
    end
  end

  assign stat_enq     = r_stat_enq;
  assign stat_bp      = r_stat_bp;
  assign stat_max_occ = r_stat_max;
`endif

endmodule
